mp3_track_selector: RTL and testbench

Parametrised successor to the MP3 song-select logic. Debounces prev/next buttons, produces single-step and held auto-repeat track changes, auto-advances on end-of-song, and supports loop, repeat-one, shuffle and stop-at-end play modes. Sits between the board button inputs and the MP3 playback/ROM address logic; `select` drives track choice directly.

---
 rtl/mp3_pkg.sv | 19 +
 rtl/mp3_button_debounce.sv | 107 ++++++++++
 rtl/mp3_track_selector.sv | 130 +++++++++++++
 tb/tb_mp3_track_selector.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// Shared encodings for the MP3 track selector: play modes, shuffle LFSR taps
// and the button debouncer state type.
package mp3_pkg;

    localparam logic [1:0] MODE_LOOP    = 2'd0;
    localparam logic [1:0] MODE_REPEAT1 = 2'd1;
    localparam logic [1:0] MODE_SHUFFLE = 2'd2;
    localparam logic [1:0] MODE_STOP    = 2'd3;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, PRESS, HOLD, REPEAT} deb_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/mp3_button_debounce.sv
// One button: 2-FF synchroniser, tick-sampled debounce, hold and auto-repeat.
// `step` is a single-cycle pulse on press acceptance, on entry to REPEAT and on
// every REPEAT_TICKS high samples thereafter.
module mp3_button_debounce
    import mp3_pkg::*;
#(
    parameter int DEB_TICKS    = 10,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic tick,
    output logic step
);

    localparam int DW   = $clog2(DEB_TICKS + 1);
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CW   = $clog2(HMAX + 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_TICKS);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

    logic [1:0]    sync_q, sync_d;
    deb_state_t    state_q, state_d;
    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          smp;

    assign smp = sync_q[1];

    // State register for synchroniser, FSM and run/hold counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce/hold/repeat next state; all timing moves only on tick
    always_comb begin
        sync_d  = {sync_q[0], btn};
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        // PRESS lasts a single cycle before hold counting begins
        if (state_q == PRESS) state_d = HOLD;
        if (tick) begin
            if (smp) begin
                hi_d = (hi_q == DEB_MAX) ? hi_q : hi_q + DW'(1);
                lo_d = '0;
            end else begin
                lo_d = (lo_q == DEB_MAX) ? lo_q : lo_q + DW'(1);
                hi_d = '0;
            end
            case (state_q)
                IDLE: begin
                    if (hi_d == DEB_MAX) begin
                        state_d = PRESS;
                        cnt_d   = '0;
                        step    = 1'b1;
                    end
                end
                PRESS, HOLD: begin
                    if (smp) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = REPEAT;
                            cnt_d   = '0;
                            step    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (smp) begin
                        if (cnt_q == REP_LAST) begin
                            cnt_d = '0;
                            step  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
            // Release wins from any pressed state
            if (state_q != IDLE && lo_d == DEB_MAX) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

endmodule

// File: rtl/mp3_track_selector.sv
// Track selector: sample tick, two debounced buttons, step/song_end
// arbitration, play-mode rules and the shuffle LFSR.
module mp3_track_selector
    import mp3_pkg::*;
#(
    parameter int          TRACK_NUM    = 4,
    parameter int          SEL_W        = $clog2(TRACK_NUM),
    parameter int          TICK_CYCLES  = 100000,
    parameter int          DEB_TICKS    = 10,
    parameter int          HOLD_TICKS   = 500,
    parameter int          REPEAT_TICKS = 200,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev,
    input  logic             next,
    input  logic             song_end,
    input  logic [1:0]       mode,
    output logic [SEL_W-1:0] select,
    output logic             track_changed,
    output logic             stopped
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(TRACK_NUM - 1);

    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic             track_changed_q, track_changed_d;
    logic             stopped_q, stopped_d;
    logic             tick, step_prev, step_next;
    logic [SEL_W-1:0] sel_inc, sel_dec, shuf_cand, sel_shuf;

    mp3_button_debounce #(
        .DEB_TICKS   (DEB_TICKS),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_prev (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (prev),
        .tick (tick),
        .step (step_prev)
    );

    mp3_button_debounce #(
        .DEB_TICKS   (DEB_TICKS),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) u_next (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (next),
        .tick (tick),
        .step (step_next)
    );

    // Top-level state: tick counter, LFSR, selection and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q      <= '0;
            lfsr_q          <= LFSR_SEED;
            select_q        <= '0;
            track_changed_q <= 1'b0;
            stopped_q       <= 1'b0;
        end else begin
            tick_cnt_q      <= tick_cnt_d;
            lfsr_q          <= lfsr_d;
            select_q        <= select_d;
            track_changed_q <= track_changed_d;
            stopped_q       <= stopped_d;
        end
    end

    // Tick generation and the candidate next tracks
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        lfsr_d     = lfsr_next(lfsr_q);
        sel_inc    = (select_q == SEL_LAST) ? '0 : select_q + SEL_W'(1);
        sel_dec    = (select_q == '0) ? SEL_LAST : select_q - SEL_W'(1);
        // Modulo keeps the candidate in range for non-power-of-two counts
        shuf_cand  = SEL_W'(lfsr_q % 16'(TRACK_NUM));
        sel_shuf   = (shuf_cand == select_q) ? sel_inc : shuf_cand;
    end

    // Arbitration: simultaneous button steps cancel, a button step drops song_end
    always_comb begin
        select_d        = select_q;
        track_changed_d = 1'b0;
        stopped_d       = stopped_q && (mode == MODE_STOP);
        if (step_prev && !step_next) begin
            select_d        = sel_dec;
            track_changed_d = 1'b1;
            stopped_d       = 1'b0;
        end else if (!step_prev && (step_next || song_end)) begin
            case (mode)
                MODE_SHUFFLE: begin
                    select_d        = sel_shuf;
                    track_changed_d = 1'b1;
                end
                MODE_STOP: begin
                    if (select_q == SEL_LAST) begin
                        stopped_d = 1'b1;
                    end else begin
                        select_d        = sel_inc;
                        track_changed_d = 1'b1;
                    end
                end
                MODE_REPEAT1: begin
                    // song_end restarts the same track; a next step still advances
                    if (step_next) select_d = sel_inc;
                    track_changed_d = 1'b1;
                end
                default: begin
                    select_d        = sel_inc;
                    track_changed_d = 1'b1;
                end
            endcase
        end
    end

    assign select        = select_q;
    assign track_changed = track_changed_q;
    assign stopped       = stopped_q;

endmodule

// File: tb/tb_mp3_track_selector.sv
// Randomised and directed bench for mp3_track_selector with a tick-level
// behavioural model compared against the outputs every cycle.
module tb_mp3_track_selector;

    localparam int N    = 5;
    localparam int TC   = 4;
    localparam int DEB  = 2;
    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       prev = 1'b0;
    logic       next = 1'b0;
    logic       song_end = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] select;
    logic       track_changed;
    logic       stopped;

    mp3_track_selector #(
        .TRACK_NUM   (N),
        .TICK_CYCLES (TC),
        .DEB_TICKS   (DEB),
        .HOLD_TICKS  (HOLD),
        .REPEAT_TICKS(REP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prev         (prev),
        .next         (next),
        .song_end     (song_end),
        .mode         (mode),
        .select       (select),
        .track_changed(track_changed),
        .stopped      (stopped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: per button (0 prev, 1 next) pressed flag, high/low run lengths,
    // high ticks since acceptance, and the two-edge input delay.
    int b_on[2], b_hi[2], b_lo[2], b_held[2], b_d1[2], b_d2[2];
    int m_sel, m_tc, m_stop, m_ecnt, m_pulses;
    logic [15:0] m_lfsr;
    int cyc_no = 0;
    int dut_pulses = 0;
    int pulse_at[$];
    bit rec_pulses = 0;
    bit se_on_step = 0;
    bit se_hit = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            b_on[i] = 0; b_hi[i] = 0; b_lo[i] = 0; b_held[i] = 0; b_d1[i] = 0; b_d2[i] = 0;
        end
        m_sel = 0; m_tc = 0; m_stop = 0; m_ecnt = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic btn_model(input int i, input bit lvl, input bit tk, output bit st);
        int s;
        st = 0;
        s = b_d2[i];
        b_d2[i] = b_d1[i];
        b_d1[i] = lvl;
        if (tk) begin
            if (s != 0) begin b_hi[i]++; b_lo[i] = 0; end
            else begin b_lo[i]++; b_hi[i] = 0; end
            if (b_on[i] == 0) begin
                if (b_hi[i] >= DEB) begin b_on[i] = 1; b_held[i] = 0; st = 1; end
            end else begin
                if (s != 0) begin
                    b_held[i]++;
                    if (b_held[i] == HOLD || (b_held[i] > HOLD && (b_held[i] - HOLD) % REP == 0))
                        st = 1;
                end
                if (b_lo[i] >= DEB) b_on[i] = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // then compare all outputs on the following falling edge.
    task automatic cyc(input bit p, input bit n, input bit se_in);
        bit tk, sp, sn, se;
        int cand, shuf, md;
        se = se_in; sp = 0; sn = 0;
        prev = p;
        next = n;
        if (!rst_n) begin
            model_reset();
        end else begin
            tk = (m_ecnt % TC) == TC - 1;
            m_ecnt++;
            btn_model(0, p, tk, sp);
            btn_model(1, n, tk, sn);
            if (se_on_step && sn) begin se = 1; se_hit = 1; end
            md = int'(mode);
            cand = int'(m_lfsr) % N;
            shuf = (cand == m_sel) ? (m_sel + 1) % N : cand;
            m_tc = 0;
            if (md != 3) m_stop = 0;
            if (sp && !sn) begin
                m_sel = (m_sel + N - 1) % N; m_tc = 1; m_stop = 0;
            end else if (!sp && (sn || se)) begin
                if (md == 2) begin m_sel = shuf; m_tc = 1; end
                else if (md == 3 && m_sel == N - 1) m_stop = 1;
                else if (md == 1 && !sn) m_tc = 1;
                else begin m_sel = (m_sel + 1) % N; m_tc = 1; end
            end
            m_pulses += m_tc;
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        song_end = se;
        @(negedge clk);
        cyc_no++;
        if (track_changed) begin
            dut_pulses++;
            if (rec_pulses) pulse_at.push_back(cyc_no);
        end
        chk("select", int'(select), m_sel);
        chk("track_changed", int'(track_changed), m_tc);
        chk("stopped", int'(stopped), m_stop);
    endtask

    task automatic drive(input bit p, input bit n, input int len);
        for (int i = 0; i < len; i++) cyc(p, n, 1'b0);
    endtask

    initial begin
        int p0, mp0, s0, len, gap, kind, old;
        bit last_se, se;
        model_reset();
        m_pulses = 0;

        // 1: reset, single next press, glitch
        rst_n = 1'b0;
        drive(0, 0, 3);
        rst_n = 1'b1;
        chk("reset_select", int'(select), 0);
        chk("reset_tc", int'(track_changed), 0);
        chk("reset_stopped", int'(stopped), 0);
        p0 = dut_pulses;
        drive(0, 1, 20);
        drive(0, 0, 20);
        chk("s1_select", int'(select), 1);
        chk("s1_pulses", dut_pulses - p0, 1);
        drive(0, 1, 3);
        drive(0, 0, 20);
        chk("s1_glitch_select", int'(select), 1);

        // 2: prev wrap and next wrap
        drive(1, 0, 20); drive(0, 0, 20);
        chk("s2_prev_to0", int'(select), 0);
        drive(1, 0, 20); drive(0, 0, 20);
        chk("s2_prev_wrap", int'(select), 4);
        drive(0, 1, 20); drive(0, 0, 20);
        chk("s2_next_wrap", int'(select), 0);

        // 3: long hold with auto-repeat
        pulse_at.delete();
        rec_pulses = 1;
        p0 = dut_pulses; mp0 = m_pulses; s0 = int'(select);
        drive(0, 1, 200);
        drive(0, 0, 20);
        rec_pulses = 0;
        chk("s3_pulse_count", dut_pulses - p0, m_pulses - mp0);
        chk("s3_select_vs_pulses", int'(select), (s0 + dut_pulses - p0) % N);
        if (pulse_at.size() >= 3) begin
            chk("s3_hold_gap", pulse_at[1] - pulse_at[0], 4 * HOLD);
            chk("s3_repeat_gap", pulse_at[2] - pulse_at[1], 4 * REP);
        end else begin
            chk("s3_enough_pulses", pulse_at.size(), 3);
        end

        // 4: stop-at-end
        mode = 2'd0;
        for (int i = 0; i < 10 && m_sel != 3; i++) begin cyc(0, 0, 1); cyc(0, 0, 0); end
        chk("s4_at3", int'(select), 3);
        mode = 2'd3;
        cyc(0, 0, 1);
        chk("s4_end_to4", int'(select), 4);
        chk("s4_end_tc", int'(track_changed), 1);
        cyc(0, 0, 0);
        p0 = dut_pulses;
        cyc(0, 0, 1);
        drive(0, 0, 3);
        chk("s4_hold4", int'(select), 4);
        chk("s4_stopped", int'(stopped), 1);
        chk("s4_no_pulse", dut_pulses - p0, 0);
        drive(1, 0, 20); drive(0, 0, 20);
        chk("s4_prev_sel", int'(select), 3);
        chk("s4_prev_unstop", int'(stopped), 0);
        cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0);
        chk("s4_restopped", int'(stopped), 1);
        mode = 2'd0;
        cyc(0, 0, 0);
        chk("s4_mode_unstop", int'(stopped), 0);

        // 5: repeat-one and shuffle
        for (int i = 0; i < 10 && m_sel != 2; i++) begin cyc(0, 0, 1); cyc(0, 0, 0); end
        mode = 2'd1;
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        chk("s5_rep1_sel", int'(select), 2);
        chk("s5_rep1_tc", int'(track_changed), 1);
        cyc(0, 0, 0);
        mode = 2'd2;
        for (int i = 0; i < 50; i++) begin
            old = int'(select);
            cyc(0, 0, 1);
            chk("s5_shuf_changed", int'(int'(select) != old), 1);
            chk("s5_shuf_range", int'(int'(select) <= N - 1), 1);
            cyc(0, 0, 0);
        end

        // 6: cancelling steps, step vs song_end, reset during repeat
        mode = 2'd0;
        s0 = int'(select);
        drive(1, 1, 20); drive(0, 0, 20);
        chk("s6_both_nochange", int'(select), s0);
        s0 = int'(select); p0 = dut_pulses;
        se_on_step = 1; se_hit = 0;
        drive(0, 1, 20);
        se_on_step = 0;
        drive(0, 0, 20);
        chk("s6_coincide_hit", int'(se_hit), 1);
        chk("s6_coincide_sel", int'(select), (s0 + 1) % N);
        chk("s6_coincide_pulses", dut_pulses - p0, 1);
        drive(0, 1, 60);
        rst_n = 1'b0;
        drive(0, 1, 3);
        rst_n = 1'b1;
        p0 = dut_pulses;
        drive(0, 1, 6);
        chk("s6_rst_sel", int'(select), 0);
        chk("s6_rst_quiet", dut_pulses - p0, 0);
        drive(0, 1, 10);
        chk("s6_rst_redeb_sel", int'(select), 1);
        chk("s6_rst_redeb_pulses", dut_pulses - p0, 1);
        drive(0, 0, 20);

        // Random traffic
        last_se = 0;
        for (int seg = 0; seg < 80; seg++) begin
            kind = $urandom_range(0, 5);
            len  = $urandom_range(1, 70);
            gap  = $urandom_range(5, 30);
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            for (int i = 0; i < len + gap; i++) begin
                se = ($urandom_range(0, 15) == 0) && !last_se;
                cyc((i < len) && (kind == 0 || kind == 2), (i < len) && (kind == 1 || kind == 2), se);
                last_se = se;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
